// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: plays an 8-bit pattern one bit per time slot, bit 0 first.
// New configurations are double-buffered and only take effect at a pattern-cycle boundary.
module led_seq_ctrl #(
  parameter int unsigned SLOTS = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [SLOTS-1:0]           led_ctrl,
  input  logic [31:0]                led_time_set,
  input  logic                       cfg_valid,
  input  logic                       enable,
  output logic                       led,
  output logic [$clog2(SLOTS)-1:0]   slot_idx,
  output logic                       cycle_done,
  output logic                       busy,
  output logic                       cfg_pending
);

  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned TIME_W = 32;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state;
  logic [TIME_W-1:0]   tick;
  logic [TIME_W-1:0]   active_time;
  logic [TIME_W-1:0]   shadow_time;
  logic [SLOTS-1:0]    active_pat;
  logic [SLOTS-1:0]    shadow_pat;

  logic [TIME_W-1:0]   last_tick_c;
  logic [TIME_W-1:0]   tick_inc_c;
  logic [SLOT_W-1:0]   next_slot_c;
  logic                slot_end_c;

  // Slot bookkeeping shared by the sequencing logic
  assign last_tick_c = active_time - TIME_W'(1);
  assign tick_inc_c  = tick + TIME_W'(1);
  assign next_slot_c = slot_idx + SLOT_W'(1);
  assign slot_end_c  = (tick == last_tick_c);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      tick        <= '0;
      active_time <= '0;
      shadow_time <= '0;
      active_pat  <= '0;
      shadow_pat  <= '0;
      led         <= 1'b0;
      slot_idx    <= '0;
      cycle_done  <= 1'b0;
      busy        <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      cycle_done <= 1'b0;

      // Shadow capture runs in every state; a strobe in LOAD re-arms cfg_pending below
      if (cfg_valid) begin
        shadow_pat  <= led_ctrl;
        shadow_time <= led_time_set;
        cfg_pending <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          led      <= 1'b0;
          busy     <= 1'b0;
          tick     <= '0;
          slot_idx <= '0;
          if (enable && cfg_pending) begin
            state <= LOAD;
          end else if (enable && (active_time != '0)) begin
            state <= RUN;
            busy  <= 1'b1;
            led   <= active_pat[0];
          end
        end

        LOAD: begin
          active_pat  <= shadow_pat;
          active_time <= shadow_time;
          tick        <= '0;
          if (!cfg_valid) begin
            cfg_pending <= 1'b0;
          end
          if (enable && (shadow_time != '0)) begin
            state    <= RUN;
            busy     <= 1'b1;
            led      <= shadow_pat[0];
            slot_idx <= '0;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            led      <= 1'b0;
            slot_idx <= '0;
          end
        end

        RUN: begin
          if (!enable) begin
            state    <= IDLE;
            led      <= 1'b0;
            slot_idx <= '0;
            tick     <= '0;
            busy     <= 1'b0;
          end else if (slot_end_c) begin
            tick <= '0;
            if ((slot_idx == LAST_SLOT) && cfg_pending) begin
              // led and slot_idx hold through the LOAD cycle
              state <= LOAD;
              busy  <= 1'b0;
            end else begin
              slot_idx   <= next_slot_c;
              led        <= active_pat[next_slot_c];
              cycle_done <= (next_slot_c == LAST_SLOT) && (active_time == TIME_W'(1));
            end
          end else begin
            tick       <= tick_inc_c;
            // Asserted while the final tick of the last slot is being played
            cycle_done <= (slot_idx == LAST_SLOT) && (tick_inc_c == last_tick_c);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          led   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios plus a random phase,
// compared every cycle against an elapsed-time model of the pattern player.
module tb_led_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  led_ctrl;
  logic [31:0] led_time_set;
  logic        cfg_valid;
  logic        enable;
  logic        led;
  logic [2:0]  slot_idx;
  logic        cycle_done;
  logic        busy;
  logic        cfg_pending;

  led_seq_ctrl #(.SLOTS(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .led_ctrl     (led_ctrl),
    .led_time_set (led_time_set),
    .cfg_valid    (cfg_valid),
    .enable       (enable),
    .led          (led),
    .slot_idx     (slot_idx),
    .cycle_done   (cycle_done),
    .busy         (busy),
    .cfg_pending  (cfg_pending)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  string phase = "reset";

  // Model: mode 0=idle, 1=loading, 2=playing; position tracked as cycles elapsed in the pattern
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  int          m_mode = M_IDLE;
  longint      m_el = 0;
  longint      m_atime = 0;
  longint      m_stime = 0;
  logic [7:0]  m_apat = '0;
  logic [7:0]  m_spat = '0;
  logic        m_pend = 1'b0;
  logic        exp_led = 1'b0;
  int          exp_slot = 0;
  logic        exp_done = 1'b0;
  logic        exp_busy = 1'b0;

  task automatic model_step();
    if (Reset) begin
      m_mode = M_IDLE; m_el = 0; m_atime = 0; m_stime = 0;
      m_apat = '0; m_spat = '0; m_pend = 1'b0;
      exp_led = 1'b0; exp_slot = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (enable && m_pend) m_mode = M_LOAD;
          else if (enable && m_atime != 0) begin m_mode = M_RUN; m_el = 0; end
        end
        M_LOAD: begin
          m_apat = m_spat; m_atime = m_stime; m_pend = 1'b0; m_el = 0;
          m_mode = (enable && m_atime != 0) ? M_RUN : M_IDLE;
        end
        default: begin
          if (!enable) m_mode = M_IDLE;
          else if (m_el == 8 * m_atime - 1) begin
            if (m_pend) m_mode = M_LOAD;
            else m_el = 0;
          end else m_el++;
        end
      endcase
      if (cfg_valid) begin
        m_spat = led_ctrl; m_stime = longint'(led_time_set); m_pend = 1'b1;
      end
      if (m_mode == M_RUN) begin
        exp_slot = int'(m_el / m_atime);
        exp_led  = m_apat[exp_slot];
      end else if (m_mode == M_IDLE) begin
        exp_slot = 0;
        exp_led  = 1'b0;
      end
    end
    exp_busy = (m_mode == M_RUN);
    exp_done = (m_mode == M_RUN) && (m_el == 8 * m_atime - 1);
  endtask

  task automatic check_outputs();
    checks++;
    assert (led === exp_led) else begin
      failures++; $error("FAIL %s led got=%0b exp=%0b t=%0t", phase, led, exp_led, $time);
    end
    checks++;
    assert (slot_idx === 3'(exp_slot)) else begin
      failures++; $error("FAIL %s slot_idx got=%0d exp=%0d t=%0t", phase, slot_idx, exp_slot, $time);
    end
    checks++;
    assert (cycle_done === exp_done) else begin
      failures++; $error("FAIL %s cycle_done got=%0b exp=%0b t=%0t", phase, cycle_done, exp_done, $time);
    end
    checks++;
    assert (busy === exp_busy) else begin
      failures++; $error("FAIL %s busy got=%0b exp=%0b t=%0t", phase, busy, exp_busy, $time);
    end
    checks++;
    assert (cfg_pending === m_pend) else begin
      failures++; $error("FAIL %s cfg_pending got=%0b exp=%0b t=%0t", phase, cfg_pending, m_pend, $time);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++; $error("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      model_step();
      #1;
      check_outputs();
      cfg_valid = 1'b0;
    end
  endtask

  task automatic send_cfg(input logic [7:0] pat, input logic [31:0] t);
    led_ctrl = pat; led_time_set = t; cfg_valid = 1'b1;
    step(1);
  endtask

  task automatic wait_slot(input int slot, input string tag);
    int n = 0;
    while (!(m_mode == M_RUN && exp_slot == slot) && n < 200) begin step(1); n++; end
    checks++;
    assert (n < 200) else begin
      failures++; $error("FAIL %s wait_slot timeout got=%0d exp=%0d", tag, exp_slot, slot);
    end
  endtask

  initial begin
    Reset = 1'b1; cfg_valid = 1'b0; enable = 1'b0; led_ctrl = '0; led_time_set = '0;
    step(2);
    Reset = 1'b0;
    step(2);

    phase = "basic";
    enable = 1'b1;
    send_cfg(8'hA5, 32'd4);
    step(70);

    phase = "deferred";
    wait_slot(3, "deferred");
    send_cfg(8'hFF, 32'd2);
    check_bit("deferred_pending", cfg_pending, 1'b1);
    step(60);
    check_bit("deferred_led_ff", led, 1'b1);

    phase = "reset_mid_run";
    send_cfg(8'hA5, 32'd4);
    wait_slot(3, "reset_mid_run");
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    check_bit("reset_busy", busy, 1'b0);
    step(10);
    check_bit("reset_stays_idle", busy, 1'b0);

    phase = "zero_time";
    send_cfg(8'hFF, 32'd0);
    step(6);
    check_bit("zero_time_idle", busy, 1'b0);
    check_bit("zero_time_led", led, 1'b0);
    send_cfg(8'h01, 32'd1);
    step(24);

    phase = "enable_drop";
    send_cfg(8'hA5, 32'd4);
    wait_slot(5, "enable_drop");
    enable = 1'b0;
    step(1);
    check_bit("drop_led", led, 1'b0);
    step(3);
    enable = 1'b1;
    step(40);

    phase = "collision";
    send_cfg(8'hFF, 32'd2);
    begin
      int n = 0;
      while (m_mode != M_LOAD && n < 200) begin step(1); n++; end
      checks++;
      assert (n < 200) else begin
        failures++; $error("FAIL collision load_wait timeout got=%0d exp=%0d", m_mode, M_LOAD);
      end
    end
    send_cfg(8'h0F, 32'd3);
    check_bit("collision_pending", cfg_pending, 1'b1);
    step(60);
    check_bit("collision_applied", cfg_pending, 1'b0);

    phase = "random";
    for (int i = 0; i < 500; i++) begin
      Reset        = ($urandom_range(0, 199) == 0);
      cfg_valid    = ($urandom_range(0, 11) == 0);
      led_ctrl     = 8'($urandom);
      led_time_set = 32'($urandom_range(0, 5));
      enable       = ($urandom_range(0, 29) != 0);
      step(1);
    end
    Reset = 1'b0;
    enable = 1'b1;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequences an on-board LED from the configuration produced by the UART command decoder.
- Inputs are an 8-bit pattern (led_ctrl) and a 32-bit slot duration in clock ticks (led_time_set).
- Each pattern bit is played for one slot, bit 0 first; a full pattern cycle is 8 slots.
- New configurations are double-buffered: a config arriving mid-cycle takes effect only at a pattern-cycle boundary, so the output never glitches.

Parameters:
- SLOTS, 8, number of pattern bits per cycle. Fixed at 8; it sets the led_ctrl width and the slot_idx width of 3.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous reset, active-high
- led_ctrl  input  8  pattern; bit n drives the LED during slot n
- led_time_set  input  32  slot length in Clk cycles; 0 means disabled
- cfg_valid  input  1  one-cycle strobe; led_ctrl/led_time_set are valid in this cycle
- enable  input  1  run gate, level-sensitive
- led  output  1  LED drive, registered
- slot_idx  output  3  current slot, registered
- cycle_done  output  1  one-cycle pulse on the last tick of slot 7
- busy  output  1  high while in RUN
- cfg_pending  output  1  shadow config captured but not yet applied

Behaviour:
- Clocking and reset
  - Single clock domain; all state changes on posedge Clk.
  - Reset=1 at a clock edge forces: state=IDLE; led=0, slot_idx=0, cycle_done=0, busy=0, cfg_pending=0.
  - Reset also clears the shadow and active pattern/time registers and the tick counter to 0.
  - Reset overrides every other input, including Reset asserted mid-RUN.
- Shadow capture
  - When cfg_valid=1: shadow_pat<=led_ctrl, shadow_time<=led_time_set, cfg_pending<=1. This happens in any state.
  - Back-to-back strobes: the last one wins.
- State IDLE
  - led=0, busy=0, tick counter=0, slot_idx=0.
  - enable=1 and cfg_pending=1 -> LOAD.
  - enable=1, cfg_pending=0, active_time!=0 -> RUN; led<=active_pat[0] on the same edge.
  - Otherwise stay in IDLE.
- State LOAD (exactly 1 cycle)
  - active_pat<=shadow_pat, active_time<=shadow_time.
  - cfg_pending<=0, unless cfg_valid=1 in this same cycle, in which case cfg_pending stays 1 (the new capture wins).
  - Next state: if shadow_time==0 -> IDLE with led=0. Else -> RUN with led<=shadow_pat[0], slot_idx<=0, tick=0.
- State RUN
  - busy=1; tick increments once per cycle.
  - When tick==active_time-1: tick<=0 and slot_idx<=slot_idx+1 (wraps 7->0); led<=active_pat[next slot].
  - Each slot therefore lasts exactly active_time cycles. active_time=1 means the LED may change every cycle.
  - Last tick of slot 7: cycle_done=1 for that cycle. If cfg_pending=1 -> LOAD, with led held at its current value during the LOAD cycle. Else wrap to slot 0 and continue.
  - enable=0: next edge -> IDLE; led=0, slot_idx=0, tick=0, busy=0. The active config and cfg_pending are retained.
- Priority and width rules
  - Priority: Reset > enable=0 > cycle-boundary LOAD > slot advance.
  - tick is a 32-bit unsigned counter compared for equality with active_time-1.
  - active_time is never 0 in RUN; entry into RUN is guarded.
- Latency
  - cfg_valid while in IDLE with enable=1: cfg_pending=1 after 1 edge, LOAD after 2 edges, first led value after 3 edges.

Test Plan:
- Reset mid-run: run pattern 8'hA5/time 4, assert Reset 1 cycle during slot 3 -> next edge led=0, slot_idx=0, busy=0, cfg_pending=0; with enable=1 and no cfg_valid it stays IDLE, because active_time=0.
- Basic sequence: enable=1, cfg_valid with led_ctrl=8'hA5, led_time_set=4 -> led plays 1,0,1,0,0,1,0,1, each for exactly 4 cycles; slot_idx steps 0..7; cycle_done pulses once every 32 cycles; the pattern repeats.
- Deferred update: during slot 3 of the A5/4 run, cfg_valid with 8'hFF/2 -> cfg_pending=1; A5 finishes slot 7; one LOAD cycle; then led=1 continuously with slot_idx advancing every 2 cycles; cfg_pending=0.
- Zero time: cfg_valid with 8'hFF/0, enable=1 -> after LOAD returns to IDLE, led=0, busy=0, cfg_pending=0; a later cfg_valid with 8'h01/1 -> led high for 1 cycle then low for 7 cycles, repeating.
- Enable drop: A5/4 running, enable=0 during slot 5 -> next edge led=0, slot_idx=0, busy=0; enable=1 again -> RUN restarts at slot 0 with A5/4.
- Collision: cfg_valid asserted in the exact LOAD cycle with 8'h0F/3 -> the previous shadow is loaded, cfg_pending stays 1, and 8'h0F/3 is applied at the next cycle boundary.
